systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (NxN PEs, N*N elements per matrix).
REQ-002 SHALL have parameter DW, default 8, meaning operand/result width in bits (8-bit float format, passed through unmodified).
REQ-003 SHALL have parameter DRAIN, default 8, meaning cycles waited after the last operand before sampling results.
REQ-004 Ports: clk  input  1  rising-edge clock.
REQ-005 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-006 Ports: start  input  1  begin a job; busy  output  1  job in progress; done  output  1  one-cycle job-complete pulse.
REQ-007 Ports: in_valid  input  1; in_ready  output  1; in_a  input  DW  A element, row-major; in_b  input  DW  B element, column-major.
REQ-008 Ports: arr_a  output  N*DW  west-edge operands, row i at bits [i*DW +: DW]; arr_b  output  N*DW  north-edge operands, column j at [j*DW +: DW].
REQ-009 Ports: acc_clr  output  1  forces array accumulator inputs to zero; arr_c  input  N*N*DW  array results, PE(i,j) at [(i*N+j)*DW +: DW].
REQ-010 Ports: out_valid  output  1; out_ready  input  1; out_c  output  DW  result element; out_idx  output  clog2(N*N)  row-major index of out_c.

Function
REQ-011 SHALL implement states IDLE, LOAD, STREAM, DRAIN, UNLOAD; busy=1 in every state except IDLE.
REQ-012 IDLE -> LOAD on start=1; start SHALL be ignored in all other states.
REQ-013 LOAD: in_ready=1; each cycle with in_valid&in_ready writes in_a to A buffer[k] and in_b to B buffer[k], k incrementing 0..N*N-1; in_ready=0 outside LOAD.
REQ-014 LOAD -> STREAM on the cycle accepting element k=N*N-1; element index SHALL reset to 0.
REQ-015 STREAM SHALL last exactly 3N-2 cycles, stream counter t=0..3N-3.
REQ-016 In STREAM cycle t: arr_a row i = A[i][t-i] when 0<=t-i<N, else 0; arr_b column j = B[t-j][j] when 0<=t-j<N, else 0 (diagonal skew).
REQ-017 arr_a/arr_b SHALL be registered outputs and SHALL be 0 in every state other than STREAM.
REQ-018 acc_clr SHALL be 1 in IDLE and LOAD and 0 from the first STREAM cycle until return to IDLE.
REQ-019 STREAM -> DRAIN after t=3N-3; DRAIN SHALL last exactly DRAIN cycles.
REQ-020 On the last DRAIN cycle the full arr_c vector SHALL be snapshotted into a result buffer; DRAIN -> UNLOAD.
REQ-021 UNLOAD: out_valid=1, out_c=result[idx], out_idx=idx; idx advances only on out_valid&out_ready; out_c/out_idx SHALL hold stable while out_valid&!out_ready.
REQ-022 UNLOAD -> IDLE on the handshake of idx=N*N-1; done SHALL pulse 1 for exactly the following cycle (first IDLE cycle).
REQ-023 Counters SHALL not wrap past their terminal value; all index arithmetic SHALL be unsigned and sized to hold N*N-1 and 3N-3.
REQ-024 start asserted on the same cycle done pulses SHALL be accepted (IDLE -> LOAD).
REQ-025 in_valid during non-LOAD states and out_ready outside UNLOAD SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, all counters 0, busy=0, done=0, in_ready=0, out_valid=0, out_c=0, out_idx=0, arr_a=0, arr_b=0, acc_clr=1.
REQ-027 Reset asserted mid-job (any state) SHALL abandon the job; no done pulse; buffers need not be cleared but SHALL not be emitted.
REQ-028 After rst_n deasserts, the first state change SHALL require a fresh start.

Verification
REQ-029 Reset: hold rst_n=0 mid-STREAM -> all outputs at REQ-026 values same cycle, IDLE after release, done never pulses.
REQ-030 Skew check, N=4: load A[i][k]=i*4+k+1, B[k][j]=0x10+k*4+j -> at t=0 arr_a={0,0,0,0x01}, arr_b row0=0x10 only; at t=3 arr_a row3=0x0D, arr_b column3=0x13; t=9 all zero; STREAM exactly 10 cycles.
REQ-031 Load backpressure: in_valid toggled 1,0,1,0 -> exactly 16 elements accepted, STREAM starts the cycle after the 16th accept.
REQ-032 Unload backpressure: hold out_ready=0 for 5 cycles at idx=7 -> out_c/out_idx=7 stable; 16 total transfers, idx 0..15 in order, done one cycle after last.
REQ-033 Back-to-back: start held high through done -> second job enters LOAD the cycle done pulses; acc_clr high during second LOAD.
REQ-034 Spurious inputs: start pulses during STREAM/DRAIN and in_valid during UNLOAD -> no state, counter or buffer change.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN systolic array: buffers A/B operands, streams them
// diagonally skewed into the array edges, waits for drain, then unloads results.
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DRAIN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_a,
  input  logic [DW-1:0]               in_b,
  output logic [N*DW-1:0]             arr_a,
  output logic [N*DW-1:0]             arr_b,
  output logic                        acc_clr,
  input  logic [N*N*DW-1:0]           arr_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_c,
  output logic [$clog2(N*N)-1:0]      out_idx
);
  localparam int NN   = N * N;
  localparam int IW   = $clog2(NN);
  localparam int TL   = 3 * N - 3;
  localparam int M1   = (NN - 1 > TL) ? NN - 1 : TL;
  localparam int CMAX = (M1 > DRAIN - 1) ? M1 : DRAIN - 1;
  localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] K_LAST = CW'(NN - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TL);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_UNLOAD} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          kidx;
  logic [NN-1:0][DW-1:0]  abuf, bbuf, res;
  logic [N-1:0][DW-1:0]   nxt_a, nxt_b;

  // One shared counter: load index, stream t, drain cycle, unload index.
  assign kidx = cnt[IW-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:
        if (start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      S_LOAD:
        if (in_valid) begin
          if (cnt == K_LAST) begin
            state_nxt = S_STREAM;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + CW'(1);
        end
      S_STREAM:
        if (cnt == T_LAST) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CW'(1);
      S_DRAIN:
        if (cnt == D_LAST) begin
          state_nxt = S_UNLOAD;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CW'(1);
      S_UNLOAD:
        if (out_ready) begin
          if (cnt == K_LAST) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + CW'(1);
        end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      arr_a <= '0;
      arr_b <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= (state == S_UNLOAD) && out_ready && (cnt == K_LAST);
      arr_a <= nxt_a;
      arr_b <= nxt_b;
    end
  end

  // Edge operands are computed from the next-cycle t so the registered value
  // lines up with the STREAM cycle it belongs to. A is row-major and B is
  // column-major, so both lanes fetch buf[lane*N + (t-lane)].
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [CW-1:0] LI   = CW'(i);
    localparam logic [IW-1:0] BASE = IW'(i * N);
    logic [CW-1:0] d;
    logic          hit;
    logic [IW-1:0] addr;
    assign d        = cnt_nxt - LI;
    assign hit      = (state_nxt == S_STREAM) && (cnt_nxt >= LI) && (d < CW'(N));
    assign addr     = BASE + IW'(d);
    assign nxt_a[i] = hit ? abuf[addr] : '0;
    assign nxt_b[i] = hit ? bbuf[addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      abuf[kidx] <= in_a;
      bbuf[kidx] <= in_b;
    end
    if (state == S_DRAIN && cnt == D_LAST) res <= arr_c;
  end

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign acc_clr   = (state == S_IDLE) || (state == S_LOAD);
  assign out_valid = (state == S_UNLOAD);
  assign out_idx   = out_valid ? kidx : '0;
  assign out_c     = out_valid ? res[kidx] : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, DW=8, DRAIN=8) with a result scoreboard.
module tb_systolic_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic        busy, done, in_ready, acc_clr, out_valid;
  logic [31:0] arr_a, arr_b;
  logic [127:0] arr_c;
  logic [7:0]  out_c;
  logic [3:0]  out_idx;

  typedef struct packed { logic [3:0] idx; logic [7:0] c; } exp_t;
  exp_t q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, snap = 0;
  logic [7:0] am[4][4], bm[4][4];

  systolic_ctrl #(.N(4), .DW(8), .DRAIN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .arr_a(arr_a), .arr_b(arr_b), .acc_clr(acc_clr), .arr_c(arr_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_idx(out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array results change every cycle so the snapshot cycle is observable.
  function automatic logic [7:0] fc(int c, int e);
    return 8'(c * 5 + e * 17 + 3);
  endfunction

  always_comb begin
    arr_c = '0;
    for (int e = 0; e < 16; e++) arr_c[e*8 +: 8] = fc(cyc, e);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {out_idx, out_c}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_idx", out_idx, e.idx);
        chk("out_c", out_c, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] exp_a(int t);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (t - i >= 0 && t - i < 4) r[i*8 +: 8] = am[i][t-i];
    return r;
  endfunction

  function automatic logic [31:0] exp_b(int t);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) if (t - j >= 0 && t - j < 4) r[j*8 +: 8] = bm[t-j][j];
    return r;
  endfunction

  task automatic set_data(input int sel);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        if (sel == 0) begin
          am[i][k] = 8'(i * 4 + k + 1);
          bm[i][k] = 8'(8'h10 + i * 4 + k);
        end else begin
          am[i][k] = 8'(8'h80 + i * 7 + k * 3);
          bm[i][k] = 8'(8'hC0 - i * 5 + k);
        end
      end
  endtask

  task automatic do_start();
    chk("idle_busy", busy, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in the first LOAD cycle; returns in the first STREAM cycle.
  task automatic load_job(input bit toggle);
    int k = 0, g = 0;
    bit v;
    while (k < 16 && g < 100) begin
      v = toggle ? (g % 2 == 0) : 1'b1;
      in_valid = v;
      in_a = am[k/4][k%4];
      in_b = bm[k%4][k/4];
      chk("load_in_ready", in_ready, 1'b1);
      chk("load_acc_clr", acc_clr, 1'b1);
      if (v) begin
        if (k == 15) snap = cyc + 18;
        k++;
      end
      step();
      g++;
    end
    in_valid = 1'b0;
    for (int e = 0; e < 16; e++) q.push_back('{idx: 4'(e), c: fc(snap, e)});
  endtask

  task automatic stream_drain(input bit spur);
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("arr_a_t%0d", t), arr_a, exp_a(t));
      chk($sformatf("arr_b_t%0d", t), arr_b, exp_b(t));
      chk("stream_acc_clr", acc_clr, 1'b0);
      if (t == 0) chk("stream_in_ready", in_ready, 1'b0);
      start = spur && (t == 2);
      step();
    end
    for (int d = 0; d < 8; d++) begin
      chk("drain_arr", {arr_a, arr_b}, 64'h0);
      chk("drain_out_valid", out_valid, 1'b0);
      chk("drain_busy", busy, 1'b1);
      start    = spur && (d == 3);
      in_valid = spur && (d == 5);
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic unload(input bit bp, input bit b2b);
    int xfer = 0, hold = 0, g = 0;
    while (xfer < 16 && g < 200) begin
      chk("unload_valid", out_valid, 1'b1);
      in_valid = bp;
      in_a = 8'hEE;
      if (b2b && xfer >= 12) start = 1'b1;
      if (bp && xfer == 7 && hold < 5) begin
        out_ready = 1'b0;
        chk("bp_idx", out_idx, 4'd7);
        chk("bp_c", out_c, fc(snap, 7));
        hold++;
      end else begin
        out_ready = 1'b1;
        xfer++;
      end
      step();
      g++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("done_pulse", {done, busy}, 2'b10);
    step();
    chk("done_clear", done, 1'b0);
    if (b2b) begin
      chk("b2b_in_ready", in_ready, 1'b1);
      chk("b2b_acc_clr", acc_clr, 1'b1);
      start = 1'b0;
    end
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, in_ready, out_valid, out_c, out_idx, acc_clr}, {4'b0, 8'h0, 4'h0, 1'b1});
    chk("rst_arr", {arr_a, arr_b}, 64'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {busy, in_ready}, 2'b00);

    // Job 1: skew pattern, spurious inputs, unload backpressure, back-to-back start
    set_data(0);
    do_start();
    load_job(1'b0);
    stream_drain(1'b1);
    unload(1'b1, 1'b1);

    // Job 2: begins in LOAD immediately, load backpressure
    set_data(1);
    load_job(1'b1);
    stream_drain(1'b0);
    unload(1'b0, 1'b0);

    // Job 3: reset mid-STREAM
    set_data(0);
    do_start();
    load_job(1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, in_ready, out_valid, out_c, out_idx, acc_clr}, {4'b0, 8'h0, 4'h0, 1'b1});
    chk("midrst_arr", {arr_a, arr_b}, 64'h0);
    q.delete();
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_midrst_idle", {busy, in_ready, out_valid, acc_clr}, 4'b0001);
      step();
    end
    chk("midrst_no_done", done_cnt, dc);

    // Job 4: recovery after reset
    set_data(1);
    do_start();
    load_job(1'b0);
    stream_drain(1'b0);
    unload(1'b0, 1'b0);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
